// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the KGP-RISC execution controller.
// Holds the controller state encoding and the command opcodes that
// arrive over the cmd_valid/cmd_ready port.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_HALTED  = 2'd1,
    ST_RUNNING = 2'd2,
    ST_STEP    = 2'd3
  } exec_state_e;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_HALT = 2'b10;
  localparam logic [1:0] CMD_STEP = 2'b11;

  // Commands are only taken while the core is parked or free-running.
  function automatic logic cmdReadyIn(exec_state_e s);
    return (s == ST_HALTED) || (s == ST_RUNNING);
  endfunction

endpackage

// File: rtl/exec_cycle_counter.sv
// Saturating counter of cycles in which the core was allowed to advance.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   i_en      - count this cycle
//   o_count   - current count, sticks at all-ones
module exec_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Stop at all-ones so a long run never wraps back to a small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/exec_controller.sv
// Run/halt/step sequencer for the single-cycle KGP-RISC core.
// Generates the core-wide advance enable and a held core reset, takes
// RUN/HALT/STEP commands, and stops on a PC breakpoint or a retired
// halt instruction.
// Optional feature macro: EXEC_CYCLE_COUNT_EN enables the saturating
// enabled-cycle counter; without it cycle_count is tied to zero.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   cmd_valid/cmd_op      - command request (NOP/RUN/HALT/STEP)
//   cmd_ready             - command accepted when valid & ready
//   bp_en/bp_addr         - PC breakpoint
//   pc, halt_insn         - current core PC and decoded halt opcode
//   core_en               - core advance enable (combinational)
//   core_rst              - registered reset to the core
//   state                 - HOLD/HALTED/RUNNING/STEP
//   bp_hit                - one-cycle pulse after a breakpoint stop
//   cycle_count           - enabled-cycle count
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W       = 12,
  parameter int CNT_W      = 32,
  parameter int RESET_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_insn,
  output logic             core_en,
  output logic             core_rst,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  exec_state_e       r_state;
  exec_state_e       w_nextState;
  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_skipBp;
  logic              r_bpHit;
  logic              r_coreRst;
  logic              w_cmdAccept;
  logic              w_bpMatch;
  logic              w_coreEn;
  logic              w_cmdReady;

  assign w_cmdAccept = cmd_valid && w_cmdReady;

  // skip_bp masks the breakpoint for the first RUNNING cycle so a RUN
  // issued while parked on the breakpoint PC can move past it.
  assign w_bpMatch = (r_state == ST_RUNNING) && bp_en && (pc == bp_addr) && !r_skipBp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A breakpoint outranks a HALT command, which outranks halt_insn; all
  // three park the core, but only the breakpoint blocks this cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_HOLD: begin
        if (r_holdCnt == HOLD_LAST) w_nextState = ST_HALTED;
      end
      ST_HALTED: begin
        if (w_cmdAccept && (cmd_op == CMD_RUN))  w_nextState = ST_RUNNING;
        if (w_cmdAccept && (cmd_op == CMD_STEP)) w_nextState = ST_STEP;
      end
      ST_RUNNING: begin
        if (w_bpMatch || (w_cmdAccept && (cmd_op == CMD_HALT)) || halt_insn) begin
          w_nextState = ST_HALTED;
        end
      end
      ST_STEP: begin
        w_nextState = ST_HALTED;
      end
      default: begin
        w_nextState = ST_HOLD;
      end
    endcase
  end

  // STEP always advances exactly one instruction, ignoring breakpoints.
  always_comb begin
    w_cmdReady = cmdReadyIn(r_state);
    w_coreEn   = 1'b0;
    case (r_state)
      ST_RUNNING: w_coreEn = !w_bpMatch;
      ST_STEP:    w_coreEn = 1'b1;
      default:    w_coreEn = 1'b0;
    endcase
  end

  // The hold counter only advances in HOLD; core_rst is registered from
  // the next state so it falls on the same edge that enters HALTED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdCnt <= '0;
      r_skipBp  <= 1'b0;
      r_bpHit   <= 1'b0;
      r_coreRst <= 1'b1;
    end else begin
      if ((r_state == ST_HOLD) && (r_holdCnt != HOLD_LAST)) begin
        r_holdCnt <= r_holdCnt + HOLD_W'(1);
      end
      if ((r_state == ST_HALTED) && w_cmdAccept && (cmd_op == CMD_RUN)) begin
        r_skipBp <= 1'b1;
      end else if (r_state == ST_RUNNING) begin
        r_skipBp <= 1'b0;
      end
      r_bpHit   <= w_bpMatch;
      r_coreRst <= (w_nextState == ST_HOLD);
    end
  end

  assign cmd_ready = w_cmdReady;
  assign core_en   = w_coreEn;
  assign core_rst  = r_coreRst;
  assign state     = r_state;
  assign bp_hit    = r_bpHit;

`ifdef EXEC_CYCLE_COUNT_EN
  exec_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cycleCounter (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_coreEn),
    .o_count(cycle_count)
  );
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: a table of cycle vectors,
// hand-written cycle-counter/reset sequences, and a randomized run
// checked against a behavioural model of the run/halt/step rules.
module tb_exec_controller;
  import exec_ctrl_pkg::*;

  localparam int TB_CNT_W   = 8;
  localparam int RESET_HOLD = 4;
`ifdef EXEC_CYCLE_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmdValid = 1'b0;
  logic [1:0]          cmdOp = CMD_NOP;
  logic                bpEn = 1'b0;
  logic [11:0]         bpAddr = '0;
  logic [11:0]         pc = '0;
  logic                haltInsn = 1'b0;
  logic                cmdReady;
  logic                coreEn;
  logic                coreRst;
  logic [1:0]          state;
  logic                bpHit;
  logic [TB_CNT_W-1:0] cycleCount;

  int checks = 0;
  int errors = 0;

  exec_controller #(
    .PC_W(12),
    .CNT_W(TB_CNT_W),
    .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmdValid),
    .cmd_op     (cmdOp),
    .cmd_ready  (cmdReady),
    .bp_en      (bpEn),
    .bp_addr    (bpAddr),
    .pc         (pc),
    .halt_insn  (haltInsn),
    .core_en    (coreEn),
    .core_rst   (coreRst),
    .state      (state),
    .bp_hit     (bpHit),
    .cycle_count(cycleCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cmdValid;
    logic [1:0]  cmdOp;
    logic        bpEn;
    logic [11:0] bpAddr;
    logic [11:0] pc;
    logic        haltInsn;
    logic [1:0]  expState;
    logic        expEn;
    logic        expReady;
    logic        expCoreRst;
    logic        expBpHit;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic v, input logic [1:0] op,
                        input logic be, input logic [11:0] ba, input logic [11:0] p,
                        input logic h, input logic [1:0] es, input logic ee,
                        input logic er, input logic ecr, input logic ebh);
    vec_t x;
    x.rst = r; x.cmdValid = v; x.cmdOp = op; x.bpEn = be; x.bpAddr = ba;
    x.pc = p; x.haltInsn = h; x.expState = es; x.expEn = ee;
    x.expReady = er; x.expCoreRst = ecr; x.expBpHit = ebh;
    vecs.push_back(x);
  endtask

  // Drive one cycle's inputs just after the falling edge, then let the
  // combinational outputs settle before anything is sampled.
  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] op,
                               input logic be, input logic [11:0] ba,
                               input logic [11:0] p, input logic h);
    @(negedge clk);
    rst = r; cmdValid = v; cmdOp = op; bpEn = be; bpAddr = ba; pc = p; haltInsn = h;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] es, input logic ee,
                          input logic er, input logic ecr, input logic ebh);
    checkOutput({tag, ".state"},     32'(state),    32'(es));
    checkOutput({tag, ".core_en"},   32'(coreEn),   32'(ee));
    checkOutput({tag, ".cmd_ready"}, 32'(cmdReady), 32'(er));
    checkOutput({tag, ".core_rst"},  32'(coreRst),  32'(ecr));
    checkOutput({tag, ".bp_hit"},    32'(bpHit),    32'(ebh));
  endtask

  // Behavioural model: mode numbers follow the reported state values.
  int mMode;
  int mEdgesSinceRelease;
  bit mSkip;
  bit mBpHit;
  int mCount;

  task automatic modelReset();
    mMode = 0; mEdgesSinceRelease = 0; mSkip = 0; mBpHit = 0; mCount = 0;
  endtask

  initial begin
    int expCount;
    logic [11:0] rPc;
    logic [11:0] rBp;
    logic rBpEn;

    // Reset release, RUN to breakpoint, resume over it, re-arm, three
    // back-to-back STEPs, then HALT/halt_insn/breakpoint priority.
    //     rst v  op        bpEn bpAddr  pc      h    st en rdy crst hit
    addVec(1, 0, CMD_NOP,  1, 12'h010, 12'h00C, 0,   0, 0, 0, 1, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h00C, 0,   0, 0, 0, 1, 0);
    addVec(0, 1, CMD_RUN,  1, 12'h010, 12'h00C, 0,   0, 0, 0, 1, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h00C, 0,   0, 0, 0, 1, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h00C, 0,   0, 0, 0, 1, 0);
    addVec(0, 1, CMD_RUN,  1, 12'h010, 12'h00C, 0,   1, 0, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h00C, 0,   2, 1, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h00D, 0,   2, 1, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h00E, 0,   2, 1, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h00F, 0,   2, 1, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h010, 0,   2, 0, 1, 0, 0);
    addVec(0, 1, CMD_RUN,  1, 12'h010, 12'h010, 0,   1, 0, 1, 0, 1);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h010, 0,   2, 1, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h011, 0,   2, 1, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h010, 12'h010, 0,   2, 0, 1, 0, 0);
    addVec(0, 1, CMD_STEP, 1, 12'h010, 12'h010, 0,   1, 0, 1, 0, 1);
    addVec(0, 1, CMD_STEP, 1, 12'h010, 12'h010, 1,   3, 1, 0, 0, 0);
    addVec(0, 1, CMD_STEP, 1, 12'h010, 12'h011, 0,   1, 0, 1, 0, 0);
    addVec(0, 1, CMD_STEP, 1, 12'h010, 12'h011, 0,   3, 1, 0, 0, 0);
    addVec(0, 1, CMD_STEP, 1, 12'h010, 12'h012, 0,   1, 0, 1, 0, 0);
    addVec(0, 1, CMD_STEP, 1, 12'h010, 12'h012, 0,   3, 1, 0, 0, 0);
    addVec(0, 1, CMD_RUN,  1, 12'h010, 12'h020, 0,   1, 0, 1, 0, 0);
    addVec(0, 1, CMD_HALT, 1, 12'h010, 12'h020, 1,   2, 1, 1, 0, 0);
    addVec(0, 1, CMD_RUN,  1, 12'h031, 12'h030, 0,   1, 0, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h031, 12'h030, 0,   2, 1, 1, 0, 0);
    addVec(0, 1, CMD_HALT, 1, 12'h031, 12'h031, 1,   2, 0, 1, 0, 0);
    addVec(0, 0, CMD_NOP,  1, 12'h031, 12'h031, 0,   1, 0, 1, 0, 1);
    addVec(0, 0, CMD_NOP,  1, 12'h031, 12'h031, 0,   1, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].cmdValid, vecs[i].cmdOp, vecs[i].bpEn,
                    vecs[i].bpAddr, vecs[i].pc, vecs[i].haltInsn);
      checkAll($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expEn,
               vecs[i].expReady, vecs[i].expCoreRst, vecs[i].expBpHit);
    end

    // Cycle counter: RUN for 10 cycles then HALT; the HALT cycle still
    // retires, so 11 enabled cycles are expected.
    applyStimulus(1, 0, CMD_NOP, 0, 12'h000, 12'h000, 0);
    checkOutput("cnt.rstCount", 32'(cycleCount), 32'd0);
    for (int i = 0; i < RESET_HOLD; i++) applyStimulus(0, 0, CMD_NOP, 0, 12'h000, 12'h000, 0);
    applyStimulus(0, 1, CMD_RUN, 0, 12'h000, 12'h000, 0);
    checkAll("cnt.runAccept", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, CMD_NOP, 0, 12'h000, 12'(i), 0);
      checkOutput($sformatf("cnt.run%0d.core_en", i), 32'(coreEn), 32'd1);
    end
    applyStimulus(0, 1, CMD_HALT, 0, 12'h000, 12'h00A, 0);
    checkOutput("cnt.haltCycle.core_en", 32'(coreEn), 32'd1);
    applyStimulus(0, 0, CMD_NOP, 0, 12'h000, 12'h00B, 0);
    expCount = COUNT_EN ? 11 : 0;
    checkOutput("cnt.afterHalt.state", 32'(state), 32'd1);
    checkOutput("cnt.afterHalt.count", 32'(cycleCount), 32'(expCount));
    applyStimulus(0, 0, CMD_NOP, 0, 12'h000, 12'h00B, 0);
    checkOutput("cnt.haltedHolds.count", 32'(cycleCount), 32'(expCount));

    // Reset in the middle of a run must clear everything without a clock edge.
    applyStimulus(0, 1, CMD_RUN, 0, 12'h000, 12'h00B, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, CMD_NOP, 0, 12'h000, 12'(12 + i), 0);
    checkOutput("midRst.before.core_en", 32'(coreEn), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst.state", 32'(state), 32'd0);
    checkOutput("midRst.core_en", 32'(coreEn), 32'd0);
    checkOutput("midRst.count", 32'(cycleCount), 32'd0);
    checkOutput("midRst.core_rst", 32'(coreRst), 32'd1);
    checkOutput("midRst.cmd_ready", 32'(cmdReady), 32'd0);

    // Randomized run against the behavioural model.
    modelReset();
    rPc = '0; rBp = 12'h005; rBpEn = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic r, v, h, accepted, match, expEn, expReady;
      logic [1:0] op;
      int nextMode;
      r = (i == 0) || ($urandom_range(0, 1999) == 0);
      v = ($urandom_range(0, 2) == 0);
      op = ($urandom_range(0, 1) == 0) ? CMD_RUN : 2'($urandom_range(0, 3));
      h = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) rBp = 12'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) rBpEn = ~rBpEn;
      if ($urandom_range(0, 15) == 0) rPc = 12'($urandom_range(0, 15));
      applyStimulus(r, v, op, rBpEn, rBp, rPc, h);
      if (r) modelReset();

      expReady = (mMode == 1) || (mMode == 2);
      match    = (mMode == 2) && rBpEn && (rPc == rBp) && !mSkip;
      expEn    = (mMode == 3) || ((mMode == 2) && !match);
      accepted = v && expReady;
      checkAll($sformatf("rnd%0d", i), 2'(mMode), expEn, expReady, (mMode == 0), mBpHit);
      checkOutput($sformatf("rnd%0d.count", i), 32'(cycleCount),
                  COUNT_EN ? 32'(mCount) : 32'd0);

      if (!r) begin
        nextMode = mMode;
        if (mMode == 0) begin
          mEdgesSinceRelease++;
          if (mEdgesSinceRelease == RESET_HOLD) nextMode = 1;
        end else if (mMode == 1) begin
          if (accepted && op == CMD_RUN) begin nextMode = 2; mSkip = 1; end
          if (accepted && op == CMD_STEP) nextMode = 3;
        end else if (mMode == 2) begin
          mSkip = 0;
          if (match || (accepted && op == CMD_HALT) || h) nextMode = 1;
        end else begin
          nextMode = 1;
        end
        mBpHit = match;
        if (expEn && mCount < (2 ** TB_CNT_W) - 1) mCount++;
        mMode = nextMode;
        if (expEn) rPc = (rPc + 12'd1) & 12'h00F;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
